// File: rtl/maxhpc_fifo_mc_pkg.sv
// ============================================================================
// Module   : maxhpc_fifo_mc_pkg
// Brief    : Shared sizing helpers for the multi-channel FIFO slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package maxhpc_fifo_mc_pkg;

    typedef enum logic {
        OREG_OFF = 1'b0,
        OREG_ON  = 1'b1
    } oreg_e;

    function automatic int ch_wd(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int cnt_wd(input int depth_wd);
        return depth_wd + 1;
    endfunction

    function automatic int usedw_lsb(input int ch, input int depth_wd);
        return ch * (depth_wd + 1);
    endfunction

    function automatic oreg_e oreg_mode(input string mode);
        return (mode == "ON") ? OREG_ON : OREG_OFF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/maxhpc_fifo_mc_if.sv
// ============================================================================
// Module   : maxhpc_fifo_mc_if
// Brief    : Write/read-request/data/status bundle of maxhpc_fifo_mc.
//            Almost flags present only with MAXHPC_FIFO_MC_ALMOST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface maxhpc_fifo_mc_if
    import maxhpc_fifo_mc_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DEPTH_WD = 4,
    parameter int DATA_WD  = 8,
    parameter int CH_WD    = ch_wd(CHANNELS)
) ();

    logic                              wr_valid;
    logic [CH_WD-1:0]                  wr_ch;
    logic [DATA_WD-1:0]                wr_data;
    logic                              wr_ready;
    logic                              rd_valid;
    logic [CH_WD-1:0]                  rd_ch;
    logic                              rd_ready;
    logic                              q_valid;
    logic [CH_WD-1:0]                  q_ch;
    logic [DATA_WD-1:0]                q;
    logic                              flush;
    logic [CH_WD-1:0]                  flush_ch;
    logic [CHANNELS-1:0]               empty;
    logic [CHANNELS-1:0]               full;
    logic [CHANNELS*(DEPTH_WD+1)-1:0]  usedw;
`ifdef MAXHPC_FIFO_MC_ALMOST_EN
    logic [CHANNELS-1:0]               almost_full;
    logic [CHANNELS-1:0]               almost_empty;
`endif

    modport master (
        output wr_valid, wr_ch, wr_data, rd_valid, rd_ch, flush, flush_ch,
        input  wr_ready, rd_ready, q_valid, q_ch, q, empty, full, usedw
`ifdef MAXHPC_FIFO_MC_ALMOST_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  wr_valid, wr_ch, wr_data, rd_valid, rd_ch, flush, flush_ch,
        output wr_ready, rd_ready, q_valid, q_ch, q, empty, full, usedw
`ifdef MAXHPC_FIFO_MC_ALMOST_EN
        , output almost_full, almost_empty
`endif
    );

endinterface

`default_nettype wire

// File: rtl/maxhpc_dpram.sv
// ============================================================================
// Module   : maxhpc_dpram
// Brief    : Simple dual-port RAM, port A write, port B registered read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maxhpc_dpram #(
    parameter int    ADDR_WD = 6,
    parameter int    DATA_WD = 8,
    parameter string USE_EAB = "ON"
) (
    input  wire logic               clock,
    input  wire logic               i_wren_a,
    input  wire logic [ADDR_WD-1:0] i_address_a,
    input  wire logic [DATA_WD-1:0] i_data_a,
    input  wire logic               i_rden_b,
    input  wire logic [ADDR_WD-1:0] i_address_b,
    output      logic [DATA_WD-1:0] o_q_b
);

    // Output only updates on a read so it holds the last word read.
    if (USE_EAB == "ON") begin : g_eab
        (* ramstyle = "M9K" *) logic [DATA_WD-1:0] r_mem [2**ADDR_WD];
        logic [DATA_WD-1:0] r_q_b;

        always_ff @(posedge clock) begin
            if (i_wren_a) begin
                r_mem[i_address_a] <= i_data_a;
            end
            if (i_rden_b) begin
                r_q_b <= r_mem[i_address_b];
            end
        end

        assign o_q_b = r_q_b;
    end else begin : g_lut
        (* ramstyle = "logic" *) logic [DATA_WD-1:0] r_mem [2**ADDR_WD];
        logic [DATA_WD-1:0] r_q_b;

        always_ff @(posedge clock) begin
            if (i_wren_a) begin
                r_mem[i_address_a] <= i_data_a;
            end
            if (i_rden_b) begin
                r_q_b <= r_mem[i_address_b];
            end
        end

        assign o_q_b = r_q_b;
    end

endmodule

`default_nettype wire

// File: rtl/maxhpc_fifo_mc_ctl.sv
// ============================================================================
// Module   : maxhpc_fifo_mc_ctl
// Brief    : Per-channel pointer/count/flag control for maxhpc_fifo_mc.
//            Almost flags built only with MAXHPC_FIFO_MC_ALMOST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maxhpc_fifo_mc_ctl
    import maxhpc_fifo_mc_pkg::*;
#(
    parameter int DEPTH_WD = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  wire logic                  clock,
    input  wire logic                  clear_n,
    input  wire logic                  i_wr,
    input  wire logic                  i_rd,
    input  wire logic                  i_flush,
    output      logic [DEPTH_WD-1:0]   o_wptr,
    output      logic [DEPTH_WD-1:0]   o_rptr,
    output      logic [DEPTH_WD:0]     o_count,
    output      logic                  o_empty,
    output      logic                  o_full
`ifdef MAXHPC_FIFO_MC_ALMOST_EN
    ,
    output      logic                  o_almost_full,
    output      logic                  o_almost_empty
`endif
);

    localparam int CW = cnt_wd(DEPTH_WD);

    logic [DEPTH_WD-1:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic [CW-1:0]       r_count, w_count_nxt;
    logic                r_empty, r_full;

    // Flush wins over a same-cycle write/read: the write pointer stays put
    // and the read pointer catches up to it.
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        if (i_flush) begin
            w_rptr_nxt  = r_wptr;
            w_count_nxt = '0;
        end else begin
            if (i_wr) begin
                w_wptr_nxt = r_wptr + DEPTH_WD'(1);
            end
            if (i_rd) begin
                w_rptr_nxt = r_rptr + DEPTH_WD'(1);
            end
            case ({i_wr, i_rd})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(1 << DEPTH_WD));
        end
    end

    assign o_wptr  = r_wptr;
    assign o_rptr  = r_rptr;
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_full  = r_full;

`ifdef MAXHPC_FIFO_MC_ALMOST_EN
    logic r_almost_full, r_almost_empty;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= CW'(AF_LEVEL));
            r_almost_empty <= (w_count_nxt <= CW'(AE_LEVEL));
        end
    end

    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
`endif

endmodule

`default_nettype wire

// File: rtl/maxhpc_fifo_mc.sv
// ============================================================================
// Module   : maxhpc_fifo_mc
// Brief    : CHANNELS logical FIFOs sharing one maxhpc_dpram, channel-tagged
//            read data. Optional almost flags: MAXHPC_FIFO_MC_ALMOST_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maxhpc_fifo_mc
    import maxhpc_fifo_mc_pkg::*;
#(
    parameter int    CHANNELS   = 4,
    parameter int    DEPTH_WD   = 4,
    parameter int    DATA_WD    = 8,
    parameter string OUTPUT_REG = "ON",
    parameter string USE_EAB    = "ON",
    parameter int    AF_LEVEL   = 12,
    parameter int    AE_LEVEL   = 2
) (
    input  wire logic         clock,
    input  wire logic         clear_n,
    maxhpc_fifo_mc_if.slave   bus
);

    localparam int    CH_WD     = ch_wd(CHANNELS);
    localparam int    CW        = cnt_wd(DEPTH_WD);
    localparam int    ADDR_WD   = CH_WD + DEPTH_WD;
    localparam oreg_e OREG_MODE = oreg_mode(OUTPUT_REG);

    logic [DEPTH_WD-1:0] w_wptr [CHANNELS];
    logic [DEPTH_WD-1:0] w_rptr [CHANNELS];
    logic [CW-1:0]       w_count [CHANNELS];
    logic [CHANNELS-1:0] w_empty, w_full, w_wr_en, w_rd_en, w_fl_en;
    logic [DEPTH_WD-1:0] w_wptr_sel, w_rptr_sel;
    logic                w_wr_ready, w_rd_ready, w_wr_acc, w_rd_acc;
    logic [DATA_WD-1:0]  w_ram_q;
    logic                r_vld1;
    logic [CH_WD-1:0]    r_ch1;

    // Channel decode by compare, so an out-of-range channel matches nothing
    // and reads back as not ready.
    always_comb begin
        w_wr_ready = 1'b0;
        w_rd_ready = 1'b0;
        w_wptr_sel = '0;
        w_rptr_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.wr_ch == CH_WD'(c)) begin
                w_wr_ready = !w_full[c];
                w_wptr_sel = w_wptr[c];
            end
            if (bus.rd_ch == CH_WD'(c)) begin
                w_rd_ready = !w_empty[c];
                w_rptr_sel = w_rptr[c];
            end
        end
    end

    assign w_wr_acc = bus.wr_valid && w_wr_ready &&
                      !(bus.flush && (bus.flush_ch == bus.wr_ch));
    assign w_rd_acc = bus.rd_valid && w_rd_ready &&
                      !(bus.flush && (bus.flush_ch == bus.rd_ch));

    assign bus.wr_ready = w_wr_ready;
    assign bus.rd_ready = w_rd_ready;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign w_wr_en[c] = w_wr_acc && (bus.wr_ch == CH_WD'(c));
        assign w_rd_en[c] = w_rd_acc && (bus.rd_ch == CH_WD'(c));
        assign w_fl_en[c] = bus.flush && (bus.flush_ch == CH_WD'(c));

        maxhpc_fifo_mc_ctl #(
            .DEPTH_WD (DEPTH_WD),
            .AF_LEVEL (AF_LEVEL),
            .AE_LEVEL (AE_LEVEL)
        ) u_ctl (
            .clock          (clock),
            .clear_n        (clear_n),
            .i_wr           (w_wr_en[c]),
            .i_rd           (w_rd_en[c]),
            .i_flush        (w_fl_en[c]),
            .o_wptr         (w_wptr[c]),
            .o_rptr         (w_rptr[c]),
            .o_count        (w_count[c]),
            .o_empty        (w_empty[c]),
            .o_full         (w_full[c])
`ifdef MAXHPC_FIFO_MC_ALMOST_EN
            ,
            .o_almost_full  (bus.almost_full[c]),
            .o_almost_empty (bus.almost_empty[c])
`endif
        );

        assign bus.usedw[usedw_lsb(c, DEPTH_WD) +: CW] = w_count[c];
    end

    maxhpc_dpram #(
        .ADDR_WD (ADDR_WD),
        .DATA_WD (DATA_WD),
        .USE_EAB (USE_EAB)
    ) u_ram (
        .clock       (clock),
        .i_wren_a    (w_wr_acc),
        .i_address_a ({bus.wr_ch, w_wptr_sel}),
        .i_data_a    (bus.wr_data),
        .i_rden_b    (w_rd_acc),
        .i_address_b ({bus.rd_ch, w_rptr_sel}),
        .o_q_b       (w_ram_q)
    );

    // Stage 1 of the q pipe lines up with the RAM output register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_vld1 <= 1'b0;
            r_ch1  <= '0;
        end else begin
            r_vld1 <= w_rd_acc;
            r_ch1  <= bus.rd_ch;
        end
    end

    if (OREG_MODE == OREG_ON) begin : g_oreg
        logic               r_vld2;
        logic [CH_WD-1:0]   r_ch2;
        logic [DATA_WD-1:0] r_q;

        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
                r_vld2 <= 1'b0;
                r_ch2  <= '0;
                r_q    <= '0;
            end else begin
                r_vld2 <= r_vld1;
                r_ch2  <= r_ch1;
                if (r_vld1) begin
                    r_q <= w_ram_q;
                end
            end
        end

        assign bus.q_valid = r_vld2;
        assign bus.q_ch    = r_ch2;
        assign bus.q       = r_q;
    end else begin : g_noreg
        assign bus.q_valid = r_vld1;
        assign bus.q_ch    = r_ch1;
        assign bus.q       = w_ram_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_maxhpc_fifo_mc.sv
// ============================================================================
// Module   : tb_maxhpc_fifo_mc
// Brief    : Self-checking bench for maxhpc_fifo_mc (4 ch x 16 x 8 bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_maxhpc_fifo_mc;

    localparam string OREG = "ON";
    localparam int    LAT  = (OREG == "ON") ? 2 : 1;

    typedef struct {
        bit          wv;
        int          wch;
        logic [7:0]  wd;
        bit          rv;
        int          rch;
        bit          ewr;
        bit          erd;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] d;
        int         due;
    } sb_t;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;

    logic [7:0] mm [4][16];
    int         mrp [4];
    int         mcnt [4];
    sb_t        sb [$];
    vec_t       t3 [6];

    maxhpc_fifo_mc_if #(.CHANNELS(4), .DEPTH_WD(4), .DATA_WD(8)) bus ();

    maxhpc_fifo_mc #(
        .CHANNELS(4), .DEPTH_WD(4), .DATA_WD(8), .OUTPUT_REG(OREG),
        .USE_EAB("ON"), .AF_LEVEL(12), .AE_LEVEL(2)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mrp[c]  = 0;
            mcnt[c] = 0;
        end
        sb.delete();
    endtask

    task automatic check_state();
        logic [19:0] eu;
        logic [3:0]  ee, ef;
        for (int c = 0; c < 4; c++) begin
            eu[c*5 +: 5] = 5'(mcnt[c]);
            ee[c]        = (mcnt[c] == 0);
            ef[c]        = (mcnt[c] == 16);
        end
        chk("usedw", 32'(bus.usedw), 32'(eu));
        chk("empty", 32'(bus.empty), 32'(ee));
        chk("full", 32'(bus.full), 32'(ef));
`ifdef MAXHPC_FIFO_MC_ALMOST_EN
        for (int c = 0; c < 4; c++) begin
            ee[c] = (mcnt[c] <= 2);
            ef[c] = (mcnt[c] >= 12);
        end
        chk("almost_empty", 32'(bus.almost_empty), 32'(ee));
        chk("almost_full", 32'(bus.almost_full), 32'(ef));
`endif
    endtask

    // One clock of stimulus; the model commits what the FIFO should accept.
    task automatic step(input bit wv, input int wch, input logic [7:0] wd,
                        input bit rv, input int rch, input bit fl, input int fch,
                        output bit wrr, output bit rdr);
        bit ewr, erd, wacc, racc;
        bus.wr_valid = wv;  bus.wr_ch = 2'(wch); bus.wr_data = wd;
        bus.rd_valid = rv;  bus.rd_ch = 2'(rch);
        bus.flush    = fl;  bus.flush_ch = 2'(fch);
        @(negedge clock);
        check_state();
        ewr = (mcnt[wch] < 16);
        erd = (mcnt[rch] > 0);
        wrr = bus.wr_ready;
        rdr = bus.rd_ready;
        chk("wr_ready", 32'(wrr), 32'(ewr));
        chk("rd_ready", 32'(rdr), 32'(erd));
        wacc = wv && ewr && !(fl && fch == wch);
        racc = rv && erd && !(fl && fch == rch);
        if (racc) begin
            sb.push_back('{ch: 2'(rch), d: mm[rch][mrp[rch]], due: cyc + LAT});
            mrp[rch] = (mrp[rch] + 1) % 16;
            mcnt[rch]--;
        end
        if (wacc) begin
            mm[wch][(mrp[wch] + mcnt[wch]) % 16] = wd;
            mcnt[wch]++;
        end
        if (fl) begin
            mrp[fch]  = (mrp[fch] + mcnt[fch]) % 16;
            mcnt[fch] = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int ch, input logic [7:0] d);
        bit a, b;
        step(1, ch, d, 0, 0, 0, 0, a, b);
    endtask

    task automatic rd(input int ch);
        bit a, b;
        step(0, 0, 8'h00, 1, ch, 0, 0, a, b);
    endtask

    task automatic idle(input int n);
        bit a, b;
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 0, 0, a, b);
    endtask

    // Output scoreboard: every q_valid must match the oldest pending read.
    always @(negedge clock) begin
        if (clear_n) begin
            if (bus.q_valid) begin
                if (sb.size() == 0) begin
                    chk("q_valid_spurious", 32'(bus.q_valid), 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("q_latency", 32'(cyc), 32'(e.due));
                    chk("q_ch", 32'(bus.q_ch), 32'(e.ch));
                    chk("q_data", 32'(bus.q), 32'(e.d));
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("q_valid_missing", 32'(bus.q_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit wrr, rdr;

        t3[0] = '{wv:1, wch:0, wd:8'hA0, rv:0, rch:1, ewr:1, erd:0};
        t3[1] = '{wv:1, wch:1, wd:8'hB0, rv:0, rch:1, ewr:1, erd:0};
        t3[2] = '{wv:1, wch:0, wd:8'hA1, rv:1, rch:1, ewr:1, erd:1};
        t3[3] = '{wv:0, wch:0, wd:8'h00, rv:1, rch:0, ewr:1, erd:1};
        t3[4] = '{wv:0, wch:0, wd:8'h00, rv:1, rch:0, ewr:1, erd:1};
        t3[5] = '{wv:0, wch:0, wd:8'h00, rv:1, rch:0, ewr:1, erd:0};

        bus.wr_valid = 0; bus.wr_ch = 0; bus.wr_data = 0;
        bus.rd_valid = 0; bus.rd_ch = 0; bus.flush = 0; bus.flush_ch = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 clear_n = 1'b1;

        chk("rst_q_valid", 32'(bus.q_valid), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'hF);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_usedw", 32'(bus.usedw), 32'h0);
        chk("rst_q", 32'(bus.q), 32'h0);

        // Fill ch2 to full, one refused write, then drain in order.
        for (int i = 0; i < 16; i++) wr(2, 8'(8'h10 + i));
        step(1, 2, 8'h99, 0, 0, 0, 0, wrr, rdr);
        chk("ch2_full_wr_ready", 32'(wrr), 32'd0);
        chk("ch2_full_flag", 32'(bus.full[2]), 32'd1);
        chk("ch2_usedw_16", 32'(bus.usedw[10 +: 5]), 32'd16);
        for (int i = 0; i < 16; i++) rd(2);
        idle(3);
        chk("ch2_drained_empty", 32'(bus.empty[2]), 32'd1);

        // Interleaved channels from the vector table.
        for (int i = 0; i < 6; i++) begin
            step(t3[i].wv, t3[i].wch, t3[i].wd, t3[i].rv, t3[i].rch, 0, 0, wrr, rdr);
            chk($sformatf("t3[%0d]_wr_ready", i), 32'(wrr), 32'(t3[i].ewr));
            chk($sformatf("t3[%0d]_rd_ready", i), 32'(rdr), 32'(t3[i].erd));
        end
        idle(3);

        // Same-channel write+read at usedw=5 and at full.
        for (int i = 0; i < 5; i++) wr(3, 8'(8'h30 + i));
        step(1, 3, 8'h3A, 1, 3, 0, 0, wrr, rdr);
        chk("ch3_wr_rd_at5", 32'({wrr, rdr}), 32'b11);
        chk("ch3_usedw_5", 32'(bus.usedw[15 +: 5]), 32'd5);
        for (int i = 0; i < 11; i++) wr(3, 8'(8'h40 + i));
        step(1, 3, 8'h3F, 1, 3, 0, 0, wrr, rdr);
        chk("ch3_wr_rd_at16", 32'({wrr, rdr}), 32'b01);
        chk("ch3_usedw_15", 32'(bus.usedw[15 +: 5]), 32'd15);
        for (int i = 0; i < 15; i++) rd(3);
        idle(3);

        // Flush ch1 with a same-cycle ch1 write and ch0 read.
        for (int i = 0; i < 7; i++) wr(1, 8'(8'h70 + i));
        wr(0, 8'hC0);
        wr(0, 8'hC1);
        step(1, 1, 8'hEE, 1, 0, 1, 1, wrr, rdr);
        chk("flush_ch1_usedw", 32'(bus.usedw[5 +: 5]), 32'd0);
        chk("flush_ch1_empty", 32'(bus.empty[1]), 32'd1);
        wr(1, 8'h55);
        step(0, 0, 8'h00, 1, 1, 0, 0, wrr, rdr);
        chk("post_flush_rd_ready", 32'(rdr), 32'd1);
        rd(0);
        idle(3);

        // Reset mid-traffic with a read in flight.
        for (int i = 0; i < 3; i++) wr(0, 8'(8'hD0 + i));
        rd(0);
        clear_n = 1'b0;
        #1;
        chk("midrst_q_valid", 32'(bus.q_valid), 32'd0);
        chk("midrst_empty", 32'(bus.empty), 32'hF);
        chk("midrst_full", 32'(bus.full), 32'h0);
        chk("midrst_usedw", 32'(bus.usedw), 32'h0);
        model_reset();
        repeat (2) @(posedge clock);
        #1 clear_n = 1'b1;
        idle(4);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

`default_nettype wire
